// File: rtl/y_buf_writer_argmax.sv
// y_buf_writer_argmax: writes final-layer FP32 class scores into y_buf at
// byte-stepped addresses and tracks a per-image running argmax.
module y_buf_writer_argmax #(
  parameter int unsigned IMG_NUM   = 1,
  parameter int unsigned NUM_CLASS = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = $clog2(NUM_CLASS * IMG_NUM * 4),
  parameter int unsigned CLS_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              score_valid_i,
  input  logic [DATA_W-1:0] score_data_i,
  output logic              score_ready_o,
  output logic              y_buf_en,
  output logic              y_buf_wr_en,
  output logic [ADDR_W-1:0] y_buf_addr,
  output logic [DATA_W-1:0] y_buf_data,
  output logic              pred_valid_o,
  output logic [CLS_W-1:0]  pred_class_o,
  output logic              done_o
);

  localparam int unsigned IMG_W = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state;
  logic [CLS_W-1:0]   cls;
  logic [IMG_W-1:0]   img;
  logic [DATA_W-1:0]  max_key;
  logic [CLS_W-1:0]   max_cls;

  logic [DATA_W-1:0]  new_key_c;
  logic               take_new_c;
  logic               last_cls_c;
  logic               last_img_c;
  logic [ADDR_W-1:0]  addr_c;

  // Order-preserving key for FP32, compare decisions and byte address of the incoming score
  always_comb begin
    new_key_c  = score_data_i[DATA_W-1] ? ~score_data_i
                                        : (score_data_i ^ {1'b1, {(DATA_W-1){1'b0}}});
    take_new_c = (cls == '0) || (new_key_c > max_key);
    last_cls_c = (cls == CLS_W'(NUM_CLASS - 1));
    last_img_c = (img == IMG_W'(IMG_NUM - 1));
    addr_c     = ADDR_W'((32'(img) * NUM_CLASS + 32'(cls)) * 32'd4);
  end

  // Run control, y_buf write port, argmax tracking and result pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cls           <= '0;
      img           <= '0;
      max_key       <= '0;
      max_cls       <= '0;
      score_ready_o <= 1'b0;
      y_buf_en      <= 1'b0;
      y_buf_wr_en   <= 1'b0;
      y_buf_addr    <= '0;
      y_buf_data    <= '0;
      pred_valid_o  <= 1'b0;
      pred_class_o  <= '0;
      done_o        <= 1'b0;
    end else begin
      y_buf_en     <= 1'b0;
      y_buf_wr_en  <= 1'b0;
      pred_valid_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: begin
          cls <= '0;
          img <= '0;
          if (start_i) begin
            state         <= RUN;
            score_ready_o <= 1'b1;
          end
        end
        RUN: begin
          if (score_valid_i) begin
            y_buf_en    <= 1'b1;
            y_buf_wr_en <= 1'b1;
            y_buf_addr  <= addr_c;
            y_buf_data  <= score_data_i;
            if (take_new_c) begin
              max_key <= new_key_c;
              max_cls <= cls;
            end
            if (last_cls_c) begin
              cls          <= '0;
              pred_valid_o <= 1'b1;
              pred_class_o <= take_new_c ? cls : max_cls;
              if (last_img_c) begin
                state         <= FIN;
                score_ready_o <= 1'b0;
                done_o        <= 1'b1;
                img           <= '0;
              end else begin
                img <= img + IMG_W'(1);
              end
            end else begin
              cls <= cls + CLS_W'(1);
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          score_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_buf_writer_argmax.sv
// Bench for y_buf_writer_argmax: two instances (IMG_NUM=1 and IMG_NUM=2) share
// one input stream; a per-instance reference model predicts every output.
module tb_y_buf_writer_argmax;

  localparam int NC = 10;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] sdata = '0;

  logic        o_ready [2];
  logic        o_en    [2];
  logic        o_wr    [2];
  logic        o_pv    [2];
  logic        o_done  [2];
  logic [31:0] o_data  [2];
  logic [3:0]  o_pc    [2];
  logic [31:0] o_addr  [2];
  logic [5:0]  addr1;
  logic [6:0]  addr2;

  assign o_addr[0] = 32'(addr1);
  assign o_addr[1] = 32'(addr2);

  y_buf_writer_argmax #(.IMG_NUM(1), .NUM_CLASS(NC)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start), .score_valid_i(valid), .score_data_i(sdata),
    .score_ready_o(o_ready[0]), .y_buf_en(o_en[0]), .y_buf_wr_en(o_wr[0]),
    .y_buf_addr(addr1), .y_buf_data(o_data[0]), .pred_valid_o(o_pv[0]),
    .pred_class_o(o_pc[0]), .done_o(o_done[0]));

  y_buf_writer_argmax #(.IMG_NUM(2), .NUM_CLASS(NC)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start), .score_valid_i(valid), .score_data_i(sdata),
    .score_ready_o(o_ready[1]), .y_buf_en(o_en[1]), .y_buf_wr_en(o_wr[1]),
    .y_buf_addr(addr2), .y_buf_data(o_data[1]), .pred_valid_o(o_pv[1]),
    .pred_class_o(o_pc[1]), .done_o(o_done[1]));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_run  [2];
  bit          m_fin  [2];
  int          m_n    [2];
  logic [31:0] m_cur  [2][16];
  logic [3:0]  m_pc   [2];
  logic        e_wr   [2];
  logic        e_pv   [2];
  logic        e_done [2];
  logic        e_ready[2];
  logic [31:0] e_addr [2];
  logic [31:0] e_data [2];

  function automatic int img_num(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // strict FP32 "greater than" with -0 below +0
  function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return !a[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic logic [3:0] argmax(input int d);
    int best = 0;
    for (int i = 1; i < NC; i++)
      if (fp_gt(m_cur[d][i], m_cur[d][best])) best = i;
    return 4'(best);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] pool [5];
    logic [31:0] v;
    pool[0] = 32'h3F80_0000; pool[1] = 32'h4000_0000; pool[2] = 32'hBF80_0000;
    pool[3] = 32'h8000_0000; pool[4] = 32'h0000_0000;
    if ($urandom_range(0, 3) == 0) begin
      v = pool[$urandom_range(0, 4)];
    end else begin
      v[31]    = 1'($urandom_range(0, 1));
      v[30:23] = 8'($urandom_range(1, 254));
      v[22:0]  = 23'($urandom);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s dut%0d t=%0t: got %h expected %h", tag, d, $time, obs, exp);
    end
  endtask

  task automatic check_all(input bit full);
    for (int d = 0; d < 2; d++) begin
      chk("ready", d, 32'(o_ready[d]), 32'(e_ready[d]));
      chk("en",    d, 32'(o_en[d]),    32'(e_wr[d]));
      chk("wr_en", d, 32'(o_wr[d]),    32'(e_wr[d]));
      chk("pred_valid", d, 32'(o_pv[d]), 32'(e_pv[d]));
      chk("done",  d, 32'(o_done[d]),  32'(e_done[d]));
      chk("pred_class", d, 32'(o_pc[d]), 32'(m_pc[d]));
      if (e_wr[d] || full) begin
        chk("addr", d, o_addr[d], e_addr[d]);
        chk("data", d, o_data[d], e_data[d]);
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_fin[d] = 0; m_n[d] = 0; m_pc[d] = '0;
      e_wr[d] = 0; e_pv[d] = 0; e_done[d] = 0; e_ready[d] = 0;
      e_addr[d] = '0; e_data[d] = '0;
    end
  endtask

  // one clock: apply inputs, advance the model, check after the edge
  task automatic step(input bit st, input bit vl, input logic [31:0] dat);
    start = st; valid = vl; sdata = dat;
    for (int d = 0; d < 2; d++) begin
      e_wr[d] = 0; e_pv[d] = 0; e_done[d] = 0;
      if (m_fin[d]) begin
        m_fin[d] = 0;
      end else if (!m_run[d]) begin
        if (st) begin m_run[d] = 1; m_n[d] = 0; end
      end else if (vl) begin
        e_wr[d] = 1;
        e_addr[d] = 32'(m_n[d] * 4);
        e_data[d] = dat;
        m_cur[d][m_n[d] % NC] = dat;
        if (m_n[d] % NC == NC - 1) begin
          e_pv[d] = 1;
          m_pc[d] = argmax(d);
        end
        m_n[d]++;
        if (m_n[d] == img_num(d) * NC) begin
          e_done[d] = 1; m_run[d] = 0; m_fin[d] = 1;
        end
      end
      e_ready[d] = m_run[d];
    end
    @(posedge clk); #1;
    check_all(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 0; valid = 0; sdata = '0;
    #2;
    model_reset();
    check_all(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic kick();
    step(0, 0, '0);
    step(1, 0, '0);
  endtask

  task automatic send_image(input logic [31:0] sc [NC], input bit gaps, input bit start_pulses);
    for (int i = 0; i < NC; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++)
          step(start_pulses && ($urandom_range(0, 1) == 1), 0, rand_fp());
      end
      step(start_pulses && ($urandom_range(0, 2) == 0), 1, sc[i]);
    end
  endtask

  initial begin
    logic [31:0] sc [NC];

    do_reset();
    step(0, 0, '0);

    // ascending 0.0 .. 9.0
    kick();
    sc[0] = 32'h0000_0000; sc[1] = 32'h3F80_0000; sc[2] = 32'h4000_0000; sc[3] = 32'h4040_0000;
    sc[4] = 32'h4080_0000; sc[5] = 32'h40A0_0000; sc[6] = 32'h40C0_0000; sc[7] = 32'h40E0_0000;
    sc[8] = 32'h4100_0000; sc[9] = 32'h4110_0000;
    send_image(sc, 0, 0);

    // negatives: -5.0 at class 3, -7.0 elsewhere
    for (int i = 0; i < NC; i++) sc[i] = 32'hC0E0_0000;
    sc[3] = 32'hC0A0_0000;
    send_image(sc, 0, 0);

    // valid while idle must not write
    step(0, 0, '0);
    step(0, 1, 32'h1234_5678);
    step(0, 1, 32'h4000_0000);

    // -0.0 at class 0, +0.0 at class 1, -1.0 elsewhere
    kick();
    for (int i = 0; i < NC; i++) sc[i] = 32'hBF80_0000;
    sc[0] = 32'h8000_0000; sc[1] = 32'h0000_0000;
    send_image(sc, 0, 0);

    // tie: 2.0 at classes 4 and 7, 1.0 elsewhere
    for (int i = 0; i < NC; i++) sc[i] = 32'h3F80_0000;
    sc[4] = 32'h4000_0000; sc[7] = 32'h4000_0000;
    send_image(sc, 0, 0);

    // randomized runs with gaps and ignored start pulses in the first image
    for (int r = 0; r < 6; r++) begin
      kick();
      for (int i = 0; i < NC; i++) sc[i] = rand_fp();
      send_image(sc, 1, 1);
      for (int i = 0; i < NC; i++) sc[i] = rand_fp();
      send_image(sc, 1, 0);
    end

    // reset in the middle of a run, then a fresh run from address 0
    kick();
    for (int i = 0; i < NC; i++) sc[i] = rand_fp();
    for (int i = 0; i < 5; i++) step(0, 1, sc[i]);
    do_reset();
    step(0, 1, 32'h3F80_0000);
    kick();
    for (int i = 0; i < NC; i++) sc[i] = rand_fp();
    send_image(sc, 0, 0);
    for (int i = 0; i < NC; i++) sc[i] = rand_fp();
    send_image(sc, 1, 0);
    step(0, 0, '0);
    step(0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
